// File: rtl/pc_sequencer.sv
// Program-counter owner for the fetch stage: issues instruction-memory requests,
// applies exception/jump/branch redirects and stalls, and drops stale fetches.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] EXC_VECTOR = 8'hF0,
  parameter int         PC_STEP    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       exc_req,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  output logic       instr_valid,
  output logic [7:0] instr_pc,
  output logic       flush
);

  localparam logic [7:0] STEP = 8'(PC_STEP);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] target_q;
  logic       redirect;
  logic [7:0] target;

  always_comb begin
    redirect = exc_req | jump | branch_taken;
    if (exc_req)
      target = EXC_VECTOR;
    else if (jump)
      target = jump_target;
    else
      target = branch_target;
  end

  // The request line is held by the address register, so req/addr stay stable until ack.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      target_q    <= 8'h00;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_pc    <= 8'h00;
      flush       <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      flush       <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pc    <= target;
              flush <= 1'b1;
            end else begin
              pc          <= pc + STEP;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
            end
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end else if (redirect) begin
            // Request still outstanding: park the target until memory answers.
            target_q <= target;
            flush    <= 1'b1;
            state    <= DRAIN;
          end
        end

        DRAIN: begin
          if (redirect)
            flush <= 1'b1;
          if (imem_ack) begin
            pc <= redirect ? target : target_q;
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end else if (redirect) begin
            target_q <= target;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc    <= target;
            flush <= 1'b1;
          end
          if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected deliveries are queued on the ack
// cycle and matched against instr_valid/instr_pc when they come out.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, branch_taken, jump, exc_req, imem_ack;
  logic [7:0] branch_target, jump_target;
  logic       imem_req, instr_valid, flush;
  logic [7:0] imem_addr, instr_pc;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         flush_cnt = 0;
  int         flush_base;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .exc_req      (exc_req),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .flush        (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic st, input logic br, input logic [7:0] bt,
                       input logic jp, input logic [7:0] jt, input logic ex);
    imem_ack = ack; stall = st; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; exc_req = ex;
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() > 0)
        chk("instr_pc", {24'h0, instr_pc}, {24'h0, exp_q.pop_front()});
      else
        chk("unexpected_instr_valid", 32'd1, 32'd0);
    end
    if (flush === 1'b1)
      flush_cnt++;
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
    tick(); tick();
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_addr", {24'h0, imem_addr}, 32'h00);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_flush", {31'h0, flush}, 32'd0);

    // Sequential, zero-wait memory
    rst_n = 1'b1;
    flush_base = flush_cnt;
    chk("boot_req", {31'h0, imem_req}, 32'd0);
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    tick();
    exp_pc = 8'h00;
    for (int i = 0; i < 6; i++) begin
      chk("seq_addr", {24'h0, imem_addr}, {24'h0, exp_pc});
      chk("seq_req", {31'h0, imem_req}, 32'd1);
      exp_q.push_back(exp_pc);
      tick();
      exp_pc = exp_pc + 8'd4;
    end

    // Three wait states per fetch
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 3; w++) begin
        drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("wait_addr", {24'h0, imem_addr}, {24'h0, exp_pc});
        chk("wait_req", {31'h0, imem_req}, 32'd1);
        tick();
      end
      drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
      chk("ack_addr", {24'h0, imem_addr}, {24'h0, exp_pc});
      exp_q.push_back(exp_pc);
      tick();
      exp_pc = exp_pc + 8'd4;
    end
    chk("seq_flush_cnt", flush_cnt - flush_base, 32'd0);

    // Redirect priority with a same-cycle ack
    drive(1, 0, 0, 8'h00, 1, 8'h10, 0);
    tick();
    chk("jmp_addr", {24'h0, imem_addr}, 32'h10);
    chk("jmp_flush", {31'h0, flush}, 32'd1);
    drive(1, 0, 1, 8'h80, 1, 8'h40, 0);
    tick();
    chk("prio_jb_addr", {24'h0, imem_addr}, 32'h40);
    chk("prio_jb_flush", {31'h0, flush}, 32'd1);
    chk("prio_jb_req", {31'h0, imem_req}, 32'd1);
    drive(1, 0, 1, 8'h80, 1, 8'h40, 1);
    tick();
    chk("prio_exc_addr", {24'h0, imem_addr}, 32'hF0);
    chk("prio_exc_flush", {31'h0, flush}, 32'd1);

    // Sequential across the wrap, then a redirect while 08 is outstanding
    exp_pc = 8'hF0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
      chk("wrap_addr", {24'h0, imem_addr}, {24'h0, exp_pc});
      exp_q.push_back(exp_pc);
      tick();
      exp_pc = exp_pc + 8'd4;
    end
    flush_base = flush_cnt;
    drive(0, 0, 1, 8'h20, 0, 8'h00, 0);
    tick();
    chk("drain_addr0", {24'h0, imem_addr}, 32'h08);
    chk("drain_req0", {31'h0, imem_req}, 32'd1);
    chk("drain_flush0", {31'h0, flush}, 32'd1);
    drive(0, 0, 0, 8'h00, 1, 8'h30, 0);
    tick();
    chk("drain_addr1", {24'h0, imem_addr}, 32'h08);
    chk("drain_flush1", {31'h0, flush}, 32'd1);
    drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("drain_addr2", {24'h0, imem_addr}, 32'h08);
    drive(1, 0, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("drain_target", {24'h0, imem_addr}, 32'h30);
    chk("drain_req", {31'h0, imem_req}, 32'd1);
    chk("drain_flush_cnt", flush_cnt - flush_base, 32'd2);

    // Stall during the FC fetch, release into the wrapped address
    drive(1, 0, 0, 8'h00, 1, 8'hFC, 0);
    tick();
    chk("stall_start", {24'h0, imem_addr}, 32'hFC);
    drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("stall_outstanding_req", {31'h0, imem_req}, 32'd1);
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    exp_q.push_back(8'hFC);
    tick();
    chk("hold_req", {31'h0, imem_req}, 32'd0);
    chk("hold_addr", {24'h0, imem_addr}, 32'h00);
    drive(0, 1, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("hold_req2", {31'h0, imem_req}, 32'd0);
    drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("release_req", {31'h0, imem_req}, 32'd1);
    chk("release_addr", {24'h0, imem_addr}, 32'h00);

    // Redirect while held
    drive(1, 1, 0, 8'h00, 0, 8'h00, 0);
    exp_q.push_back(8'h00);
    tick();
    chk("hold2_addr", {24'h0, imem_addr}, 32'h04);
    drive(0, 1, 1, 8'h50, 0, 8'h00, 0);
    tick();
    chk("hold_br_addr", {24'h0, imem_addr}, 32'h50);
    chk("hold_br_req", {31'h0, imem_req}, 32'd0);
    chk("hold_br_flush", {31'h0, flush}, 32'd1);
    drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
    tick();
    chk("hold_br_release", {31'h0, imem_req}, 32'd1);

    // Asynchronous reset while draining
    drive(0, 0, 1, 8'h20, 0, 8'h00, 0);
    tick();
    chk("pre_rst_flush", {31'h0, flush}, 32'd1);
    chk("pre_rst_addr", {24'h0, imem_addr}, 32'h50);
    drive(0, 0, 0, 8'h00, 0, 8'h00, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'd0);
    chk("mid_rst_flush", {31'h0, flush}, 32'd0);
    chk("mid_rst_addr", {24'h0, imem_addr}, 32'h00);
    tick();
    rst_n = 1'b1;
    chk("post_rst_boot", {31'h0, imem_req}, 32'd0);
    tick();
    chk("post_rst_req", {31'h0, imem_req}, 32'd1);
    chk("post_rst_addr", {24'h0, imem_addr}, 32'h00);
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
